fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, framebuffer address width.
REQ-002 SHALL have parameter DATA_W, default 3, pixel width {R,G,B}.
REQ-003 SHALL have parameter PIXELS, default 76800, valid framebuffer size (320x240).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two).
REQ-005 SHALL have port clk, input, 1, single 25 MHz pixel clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port disp_req, input, 1, display read request this cycle.
REQ-008 SHALL have port disp_addr, input, ADDR_W, display read address.
REQ-009 SHALL have port disp_valid, output, 1, read data valid (one cycle after disp_req).
REQ-010 SHALL have port disp_pixel, output, DATA_W, read pixel.
REQ-011 SHALL have ports wr_valid (input, 1), wr_ready (output, 1), wr_addr (input, ADDR_W), wr_data (input, DATA_W), writer valid/ready channel.
REQ-012 SHALL have port frame_start, input, 1, one-cycle pulse at start of each display frame.
REQ-013 SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W), single-port RAM with 1-cycle synchronous read.
REQ-014 SHALL have port pix_written, output, ADDR_W, RAM writes committed since last frame_start.
REQ-015 SHALL have port err_oob, output, 1, sticky out-of-range write flag.

Function
REQ-016 SHALL give display absolute priority: disp_req=1 -> mem_addr=disp_addr, mem_we=0, same cycle (combinational mux).
REQ-017 SHALL assert disp_valid exactly one cycle after each disp_req cycle; disp_pixel=mem_rdata when disp_valid=1, else 0.
REQ-018 SHALL sustain back-to-back display reads every cycle with no bubbles.
REQ-019 SHALL, in a cycle with disp_req=0 and FIFO non-empty, drive FIFO head onto mem_addr/mem_wdata with mem_we=1 and pop the head.
REQ-020 SHALL, when idle (disp_req=0, FIFO empty), drive mem_addr=0, mem_wdata=0, mem_we=0.
REQ-021 SHALL commit writes in acceptance order (FIFO order).
REQ-022 SHALL drive wr_ready = (count < FIFO_DEPTH) from registered state; handshake completes when wr_valid && wr_ready on a clock edge.
REQ-023 SHALL keep count unchanged on simultaneous push and pop; no push possible when full.
REQ-024 SHALL accept a handshake with wr_addr >= PIXELS but not enqueue it; err_oob set to 1 next cycle and held.
REQ-025 SHALL increment pix_written on each mem_we=1 cycle, saturating at PIXELS.
REQ-026 SHALL clear pix_written on frame_start; frame_start coincident with a commit -> pix_written=1.
REQ-027 SHALL stall writes indefinitely while disp_req stays high; FIFO fills and wr_ready drops, no data lost.
REQ-028 SHALL never assert mem_we in a disp_req=1 cycle.

Reset
REQ-029 SHALL, while reset=1, hold disp_valid=0, disp_pixel=0, wr_ready=0, mem_we=0, mem_addr=0, pix_written=0, err_oob=0, FIFO empty.
REQ-030 SHALL discard FIFO contents and any in-flight read on reset mid-operation; disp_valid=0 the cycle after reset deasserts regardless of prior disp_req.
REQ-031 SHALL assert wr_ready=1 the first cycle after reset deasserts.

Verification
REQ-032 Reads: disp_req=1 for 320 cycles, addr 0..319, RAM model addr[2:0] -> disp_valid 320 cycles delayed 1, disp_pixel matching, mem_we=0 throughout.
REQ-033 Idle write: disp_req=0, write addr 100 data 3'b101 -> mem_we=1 with mem_addr=100, mem_wdata=5 within 2 cycles; pix_written=1.
REQ-034 Backpressure: disp_req=1 held, 6 writes offered -> 4 accepted, wr_ready=0; drop disp_req -> 4 commits on 4 consecutive cycles in order, then remaining 2 accepted.
REQ-035 OOB: write addr 76800 -> accepted, no mem_we, err_oob=1 stays until reset.
REQ-036 Frame count: 10 commits, frame_start coincident with 11th commit -> pix_written=1; saturation at 76800 after 76801 commits without frame_start.
REQ-037 Reset mid-op: FIFO holding 3 entries, disp_req=1, reset 1 cycle -> no mem_we afterwards, disp_valid=0, wr_ready=1 next cycle.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter
//   Shares one single-port framebuffer RAM between a display reader and a
//   pixel writer. The display always wins the RAM port. Writes wait in a
//   small FIFO and are committed, in acceptance order, in any cycle the
//   display leaves the port free. A per-frame counter of committed writes
//   and a sticky out-of-range flag are also provided.
//
// Ports
//   clk, reset           pixel clock; synchronous active-high reset
//   disp_req, disp_addr  display read request/address (combinational to RAM)
//   disp_valid           read data valid, one cycle after disp_req
//   disp_pixel           read pixel (zero when disp_valid is low)
//   wr_valid, wr_ready   writer handshake
//   wr_addr, wr_data     writer address and pixel
//   frame_start          one-cycle pulse at the start of each display frame
//   mem_addr, mem_we     RAM address and write enable
//   mem_wdata, mem_rdata RAM write data and 1-cycle-latency read data
//   pix_written          RAM writes committed since the last frame_start
//   err_oob              sticky flag: a write outside the framebuffer was seen
module fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 3,
  parameter int PIXELS     = 76800,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_pixel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pix_written,
  output logic              err_oob
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  LP_DEPTH      = CNT_W'(FIFO_DEPTH);
  // One extra bit so the range test also works when PIXELS == 2**ADDR_W.
  localparam logic [ADDR_W:0]   LP_PIXELS_EXT = (ADDR_W + 1)'(PIXELS);
  localparam logic [ADDR_W-1:0] LP_PIX_MAX    = ADDR_W'(PIXELS);

  logic [ADDR_W-1:0] r_fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_dispValid;
  logic              r_errOob;
  logic [ADDR_W-1:0] r_pixWritten;

  logic w_wrReady;
  logic w_handshake;
  logic w_inRange;
  logic w_push;
  logic w_pop;

  // wr_ready depends only on the registered occupancy; gating with reset keeps
  // it low during reset yet lets it rise in the very first cycle afterwards.
  assign w_wrReady   = !reset && (r_count < LP_DEPTH);
  assign w_handshake = wr_valid && w_wrReady;
  assign w_inRange   = {1'b0, wr_addr} < LP_PIXELS_EXT;
  // Out-of-range writes complete the handshake but are dropped here.
  assign w_push      = w_handshake && w_inRange;
  assign w_pop       = !reset && !disp_req && (r_count != '0);

  assign wr_ready = w_wrReady;

  // RAM port mux: display first, then the FIFO head, otherwise all zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (!reset) begin
      if (disp_req) begin
        mem_addr = disp_addr;
      end else if (w_pop) begin
        mem_addr  = r_fifoAddr[r_rdPtr];
        mem_wdata = r_fifoData[r_rdPtr];
        mem_we    = 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave the
  // count unchanged; pointers wrap naturally because the depth is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoAddr[r_wrPtr] <= wr_addr;
      r_fifoData[r_wrPtr] <= wr_data;
    end
  end

  // The RAM returns data one cycle after the address, so the valid strobe is
  // simply the request delayed by one cycle. Reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dispValid <= 1'b0;
    end else begin
      r_dispValid <= disp_req;
    end
  end

  assign disp_valid = r_dispValid && !reset;
  assign disp_pixel = disp_valid ? mem_rdata : '0;

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_errOob <= 1'b0;
    end else if (w_handshake && !w_inRange) begin
      r_errOob <= 1'b1;
    end
  end

  assign err_oob = r_errOob && !reset;

  // Per-frame commit counter. A commit in the frame_start cycle belongs to the
  // new frame, so the counter restarts at 1 rather than 0 in that case.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixWritten <= '0;
    end else if (frame_start) begin
      r_pixWritten <= {{(ADDR_W-1){1'b0}}, mem_we};
    end else if (mem_we && (r_pixWritten < LP_PIX_MAX)) begin
      r_pixWritten <= r_pixWritten + ADDR_W'(1);
    end
  end

  assign pix_written = reset ? '0 : r_pixWritten;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter
//   Randomised scoreboard bench for fb_arbiter. A driver applies one cycle of
//   stimulus at a time and advances a queue-based reference model of the
//   arbiter (write queue, framebuffer contents, frame counter). Expected read
//   pixels and RAM commits are queued with the cycle they must appear in; a
//   monitor on the falling edge pops and compares whatever the DUT presents.
module tb_fb_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 3;
  localparam int PIXELS = 76800;
  localparam int DEPTH  = 4;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] pix;
  } rdExp_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrExp_t;

  logic              clk;
  logic              reset;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_pixel;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] pix_written;
  logic              err_oob;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  rdExp_t            readQ[$];
  wrExp_t            commitQ[$];
  wrExp_t            modelFifo[$];
  logic [DATA_W-1:0] refMem [PIXELS];
  int                expPix     = 0;
  int                expPixNext = 0;
  bit                expErr     = 0;
  bit                expErrNext = 0;

  // Environment RAM seen by the DUT.
  logic [DATA_W-1:0] ram [PIXELS];

  fb_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .PIXELS    (PIXELS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_pixel (disp_pixel),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_start(frame_start),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_written(pix_written),
    .err_oob    (err_oob)
  );

  // 25 MHz pixel clock.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with one cycle of read latency (read-before-write).
  always @(posedge clk) begin
    if (mem_addr < PIXELS) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= '0;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock cycle of stimulus plus the matching reference-model step.
  task automatic applyStimulus(input bit rstIn, input bit dreq, input logic [ADDR_W-1:0] daddr,
                               input bit wv, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input bit fs, output bit accepted);
    bit     modelReady;
    bit     commitNow;
    rdExp_t r;
    wrExp_t h;
    @(posedge clk);
    #1;
    reset       = rstIn;
    disp_req    = dreq;
    disp_addr   = daddr;
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    frame_start = fs;

    expPix     = expPixNext;
    expErr     = expErrNext;
    accepted   = 1'b0;
    commitNow  = 1'b0;
    modelReady = !rstIn && (modelFifo.size() < DEPTH);

    if (rstIn) begin
      modelFifo.delete();
      readQ.delete();
      expPix     = 0;
      expErr     = 0;
      expPixNext = 0;
      expErrNext = 0;
    end else begin
      if (dreq) begin
        r.cyc = cyc + 1;
        r.pix = refMem[daddr];
        readQ.push_back(r);
      end else if (modelFifo.size() > 0) begin
        h     = modelFifo.pop_front();
        h.cyc = cyc;
        commitQ.push_back(h);
        refMem[h.addr] = h.data;
        commitNow = 1'b1;
      end
      if (wv && modelReady) begin
        accepted = 1'b1;
        if (wa < PIXELS) begin
          h.cyc  = 0;
          h.addr = wa;
          h.data = wd;
          modelFifo.push_back(h);
        end else begin
          expErrNext = 1'b1;
        end
      end
      if (fs) begin
        expPixNext = commitNow ? 1 : 0;
      end else if (commitNow && expPixNext < PIXELS) begin
        expPixNext++;
      end
    end

    #1;
    checkOutput("wr_ready", wr_ready, modelReady);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, '0, '0, 0, acc);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    rdExp_t r;
    wrExp_t w;
    if (reset) begin
      checkOutput("rst_disp_valid", disp_valid, 0);
      checkOutput("rst_disp_pixel", disp_pixel, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_pix_written", pix_written, 0);
      checkOutput("rst_err_oob", err_oob, 0);
    end else begin
      if (disp_valid) begin
        if (readQ.size() == 0) begin
          checkOutput("disp_valid_unexpected", 1, 0);
        end else begin
          r = readQ.pop_front();
          checkOutput("read_cycle", cyc, r.cyc);
          checkOutput("disp_pixel", disp_pixel, r.pix);
        end
      end else begin
        checkOutput("disp_pixel_idle", disp_pixel, 0);
        while (readQ.size() > 0 && readQ[0].cyc <= cyc) begin
          void'(readQ.pop_front());
          checkOutput("disp_valid_missing", 0, 1);
        end
      end

      if (mem_we) begin
        checkOutput("we_during_read", disp_req, 0);
        if (commitQ.size() == 0) begin
          checkOutput("mem_we_unexpected", 1, 0);
        end else begin
          w = commitQ.pop_front();
          checkOutput("commit_cycle", cyc, w.cyc);
          checkOutput("commit_addr", mem_addr, w.addr);
          checkOutput("commit_data", mem_wdata, w.data);
        end
      end else begin
        while (commitQ.size() > 0 && commitQ[0].cyc <= cyc) begin
          void'(commitQ.pop_front());
          checkOutput("mem_we_missing", 0, 1);
        end
        if (disp_req) begin
          checkOutput("read_addr", mem_addr, disp_addr);
        end else begin
          checkOutput("idle_addr", mem_addr, 0);
          checkOutput("idle_wdata", mem_wdata, 0);
        end
      end

      checkOutput("pix_written", pix_written, expPix);
      checkOutput("err_oob", err_oob, expErr);
    end
  end

  initial begin
    bit acc;
    int k;
    logic [ADDR_W-1:0] offAddr [6];
    logic [DATA_W-1:0] offData [6];

    for (int i = 0; i < PIXELS; i++) begin
      ram[i]    = DATA_W'(i);
      refMem[i] = DATA_W'(i);
    end
    reset       = 1'b1;
    disp_req    = 1'b0;
    disp_addr   = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    frame_start = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 0, '0, '0, 0, acc);

    // Back-to-back display reads over the first scanline.
    for (int i = 0; i < 320; i++) applyStimulus(0, 1, ADDR_W'(i), 0, '0, '0, 0, acc);
    idle(2);

    // Single write while the display is idle.
    applyStimulus(0, 0, '0, 1, ADDR_W'(100), 3'b101, 0, acc);
    idle(3);
    checkOutput("idle_write_count", pix_written, 1);

    // Backpressure: display holds the port while six writes are offered.
    for (int i = 0; i < 6; i++) begin
      offAddr[i] = ADDR_W'($urandom_range(0, PIXELS - 1));
      offData[i] = DATA_W'($urandom);
    end
    k = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 1, ADDR_W'($urandom_range(0, PIXELS - 1)), k < 6,
                    offAddr[k % 6], offData[k % 6], 0, acc);
      if (acc) k++;
    end
    checkOutput("bp_wr_ready_low", wr_ready, 0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, '0, k < 6, offAddr[k % 6], offData[k % 6], 0, acc);
      if (acc) k++;
    end
    idle(3);

    // Out-of-range write: accepted, never committed, flag sticks.
    applyStimulus(0, 0, '0, 1, ADDR_W'(PIXELS), 3'b111, 0, acc);
    idle(4);
    checkOutput("oob_sticky", err_oob, 1);

    // Random mixed traffic.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(0, ($urandom % 3) == 0, ADDR_W'($urandom_range(0, PIXELS - 1)),
                    $urandom_range(0, 1) == 1,
                    (($urandom % 16) == 0) ? ADDR_W'($urandom_range(PIXELS, 131071))
                                           : ADDR_W'($urandom_range(0, PIXELS - 1)),
                    DATA_W'($urandom), ($urandom % 97) == 0, acc);
    end
    idle(6);

    // Frame boundary coincident with the 11th commit.
    applyStimulus(0, 0, '0, 0, '0, '0, 1, acc);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, 0, '0, 1, ADDR_W'($urandom_range(0, PIXELS - 1)), DATA_W'($urandom), 0, acc);
    end
    applyStimulus(0, 0, '0, 0, '0, '0, 1, acc);
    idle(1);
    checkOutput("frame_restart_count", pix_written, 1);

    // Saturation of the per-frame counter.
    idle(2);
    applyStimulus(0, 0, '0, 0, '0, '0, 1, acc);
    for (int i = 0; i < PIXELS + 5; i++) begin
      applyStimulus(0, 0, '0, 1, ADDR_W'($urandom_range(0, PIXELS - 1)), DATA_W'($urandom), 0, acc);
    end
    idle(3);
    checkOutput("pix_saturate", pix_written, PIXELS);

    // Reset in mid-operation with queued writes and a read in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, ADDR_W'(i), 1, ADDR_W'(200 + i), DATA_W'(i), 0, acc);
    end
    applyStimulus(1, 1, ADDR_W'(7), 0, '0, '0, 0, acc);
    applyStimulus(0, 0, '0, 0, '0, '0, 0, acc);
    checkOutput("post_rst_wr_ready", wr_ready, 1);
    checkOutput("post_rst_disp_valid", disp_valid, 0);
    idle(6);
    checkOutput("post_rst_err_clear", err_oob, 0);

    // A little more random traffic after reset, then drain.
    for (int c = 0; c < 200; c++) begin
      applyStimulus(0, ($urandom % 2) == 0, ADDR_W'($urandom_range(0, PIXELS - 1)),
                    $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, PIXELS - 1)),
                    DATA_W'($urandom), ($urandom % 50) == 0, acc);
    end
    idle(8);
    @(posedge clk);
    #1;
    checkOutput("reads_drained", readQ.size(), 0);
    checkOutput("commits_drained", commitQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
